// File: rtl/rr_priority_arbiter_8.sv
// rtl/rr_priority_arbiter_8.sv - eight-requester arbiter with fixed/round-robin priority, hold limit and turnaround gap
module rr_priority_arbiter_8 #(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       mode,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t            state, state_next;
  logic [HOLD_W-1:0] hold_cnt, hold_next;
  logic [2:0]        last_id, last_next, id_next;
  logic [2:0]        winner, idx;
  logic [7:0]        gnt_next;
  logic              timeout_next;
  logic              found;
  logic              arb_ok;
  logic              hold_done;

  assign arb_ok    = en && (req != 8'd0);
  assign hold_done = (hold_cnt == HOLD_W'(MAX_HOLD));

  // Round-robin walks downward from last_id-1 and wraps, so last_id itself is tried last.
  always_comb begin
    winner = 3'd0;
    found  = 1'b0;
    idx    = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      idx = mode ? (last_id - 3'(k)) : 3'(8 - k);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= 8'd0;
      gnt_id    <= 3'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      hold_cnt  <= '0;
      last_id   <= 3'd0;
    end else begin
      state     <= state_next;
      gnt       <= gnt_next;
      gnt_id    <= id_next;
      gnt_valid <= |gnt_next;
      timeout   <= timeout_next;
      hold_cnt  <= hold_next;
      last_id   <= last_next;
    end
  end

  // en has priority over release, and release over timeout.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, GAP: state_next = arb_ok ? GRANT : IDLE;
      GRANT: begin
        if (!en)                state_next = IDLE;
        else if (!req[gnt_id])  state_next = GAP;
        else if (hold_done)     state_next = GAP;
        else                    state_next = GRANT;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    gnt_next     = gnt;
    id_next      = gnt_id;
    hold_next    = hold_cnt;
    last_next    = last_id;
    timeout_next = 1'b0;
    case (state)
      IDLE, GAP: begin
        if (arb_ok) begin
          gnt_next  = 8'd1 << winner;
          id_next   = winner;
          last_next = winner;
          hold_next = HOLD_W'(1);
        end else begin
          gnt_next = 8'd0;
        end
      end
      GRANT: begin
        if (state_next == GRANT) begin
          hold_next = hold_cnt + HOLD_W'(1);
        end else begin
          gnt_next     = 8'd0;
          timeout_next = en && req[gnt_id] && hold_done;
        end
      end
      default: gnt_next = 8'd0;
    endcase
  end

  a_gnt_shape: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(gnt) && (gnt_valid == (|gnt)));

endmodule

// File: tb/tb_rr_priority_arbiter_8.sv
// tb/tb_rr_priority_arbiter_8.sv - randomized and directed bench for rr_priority_arbiter_8
module tb_rr_priority_arbiter_8;

  localparam int MAX_HOLD = 16;
  localparam int S_IDLE = 0, S_GRANT = 1, S_GAP = 2;

  logic       clk, rst_n, en, mode;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid, timeout;

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_state, m_id, m_last, m_hold;
  bit m_valid, m_to;

  rr_priority_arbiter_8 #(.MAX_HOLD(MAX_HOLD), .HOLD_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .req(req),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Priority list built from the rules, first requester in the list wins.
  function automatic int ref_winner(logic [7:0] r, logic m, int last);
    int order[8];
    for (int k = 0; k < 8; k++) order[k] = m ? (last + 7 - k) % 8 : 7 - k;
    for (int k = 0; k < 8; k++) if (r[order[k]]) return order[k];
    return 0;
  endfunction

  task automatic model_reset();
    m_state = S_IDLE; m_id = 0; m_last = 0; m_hold = 0; m_valid = 0; m_to = 0;
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_to = 0;
    if (m_state == S_GRANT) begin
      if (!en) begin
        m_state = S_IDLE; m_valid = 0;
      end else if (!req[m_id]) begin
        m_state = S_GAP; m_valid = 0;
      end else if (m_hold == MAX_HOLD) begin
        m_state = S_GAP; m_valid = 0; m_to = 1;
      end else begin
        m_hold++;
      end
    end else if (en && req != 8'd0) begin
      m_id = ref_winner(req, mode, m_last);
      m_last = m_id; m_hold = 1; m_valid = 1; m_state = S_GRANT;
    end else begin
      m_state = S_IDLE; m_valid = 0;
    end
  endtask

  task automatic check_model();
    chk("gnt", 32'(gnt), m_valid ? (32'd1 << m_id) : 32'd0);
    chk("gnt_id", 32'(gnt_id), 32'(m_id));
    chk("gnt_valid", 32'(gnt_valid), 32'(m_valid));
    chk("timeout", 32'(timeout), 32'(m_to));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("async_gnt", 32'(gnt), 32'd0);
    chk("async_id", 32'(gnt_id), 32'd0);
    chk("async_valid", 32'(gnt_valid), 32'd0);
    chk("async_timeout", 32'(timeout), 32'd0);
    model_reset();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int seq[9];
    int vcnt, to_tick;
    bit seen_to;
    seq = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; req = 8'd0;
    model_reset();
    tick();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_valid", 32'(gnt_valid), 32'd0);
    rst_n = 1'b1;

    // fixed priority: 5 beats 2, one gap, then 2
    en = 1'b1; req = 8'b0010_0100;
    tick();
    chk("tp1_gnt", 32'(gnt), 32'h20);
    chk("tp1_id", 32'(gnt_id), 32'd5);
    req = 8'b0000_0100;
    tick();
    chk("tp1_gap", 32'(gnt_valid), 32'd0);
    tick();
    chk("tp1_second", 32'(gnt), 32'h04);
    req = 8'd0;
    tick(); tick();

    // round-robin vs fixed after requester 7 drops for one cycle
    for (int m = 1; m >= 0; m--) begin
      do_reset();
      mode = 1'(m); req = 8'h81;
      tick();
      chk("tp2_first", 32'(gnt_id), 32'd7);
      req = 8'h01;
      tick();
      req = 8'h81;
      tick();
      chk("tp2_next", 32'(gnt_id), m ? 32'd0 : 32'd7);
      req = 8'd0;
      tick(); tick();
    end

    // round-robin rotation with everyone requesting
    do_reset();
    mode = 1'b1; req = 8'hFF;
    tick();
    for (int i = 0; i < 9; i++) begin
      chk("tp3_id", {28'd0, gnt_valid, gnt_id}, {28'd0, 1'b1, 3'(seq[i])});
      tick();
      req = 8'hFF & ~(8'd1 << seq[i]);
      tick();
      chk("tp3_gap", 32'(gnt_valid), 32'd0);
      req = 8'hFF;
      tick();
    end
    req = 8'd0;
    tick(); tick();

    // forced release after MAX_HOLD cycles
    do_reset();
    mode = 1'b0; req = 8'b0000_1000;
    vcnt = 0; seen_to = 0; to_tick = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!seen_to) begin
        if (gnt_valid) vcnt++;
        if (timeout) begin
          seen_to = 1;
          to_tick = i;
        end
      end else if (i == to_tick + 1) begin
        chk("tp4_regrant", {28'd0, gnt_valid, gnt_id}, {28'd0, 1'b1, 3'd3});
      end
    end
    chk("tp4_len", 32'(vcnt), 32'(MAX_HOLD));
    chk("tp4_timeout_seen", 32'(seen_to), 32'd1);
    req = 8'd0;
    tick(); tick();

    // en drop forces idle without timeout, re-enable regrants
    do_reset();
    req = 8'b0001_0000;
    tick(); tick();
    chk("tp5_id", 32'(gnt_id), 32'd4);
    en = 1'b0;
    tick();
    chk("tp5_off", {30'd0, gnt_valid, timeout}, 32'd0);
    en = 1'b1;
    tick();
    chk("tp5_back", {28'd0, gnt_valid, gnt_id}, {28'd0, 1'b1, 3'd4});

    // asynchronous reset mid-grant, then last_id starts from 0
    req = 8'h40;
    tick();
    mid_reset();
    mode = 1'b1; req = 8'hFF;
    tick();
    chk("tp6_id", {28'd0, gnt_valid, gnt_id}, {28'd0, 1'b1, 3'd7});

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      en = ($urandom_range(0, 31) != 0);
      if ($urandom_range(0, 63) == 0) mode = ~mode;
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 15) == 0) req[b] = ~req[b];
      if (m_valid && $urandom_range(0, 5) == 0) req[m_id] = 1'b0;
      if ($urandom_range(0, 199) == 0) req = 8'hFF;
      if ($urandom_range(0, 599) == 0) mid_reset();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
